// File: rtl/dest_tracker_if.sv
// Bundle of ID/EX, data-memory and forwarding/control signals around dest_tracker.
// Stats ports exist only when DEST_TRACKER_STATS_EN is defined.
interface dest_tracker_if #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);
  logic [REG_AW-1:0] rd_idex;
  logic              regwrite_idex;
  logic              memread_idex;
  logic [DATA_W-1:0] alu_result_ex;
  logic [REG_AW-1:0] rs1_ifid;
  logic [REG_AW-1:0] rs2_ifid;
  logic              use_rs1_ifid;
  logic              use_rs2_ifid;
  logic              branch_taken_ex;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [REG_AW-1:0] rd_exmem;
  logic [REG_AW-1:0] rd_memwb;
  logic              regwrite_exmem;
  logic              regwrite_memwb;
  logic              memread_exmem;
  logic [DATA_W-1:0] alu_result_exmem;
  logic [DATA_W-1:0] wb_data_memwb;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              mem_err;
`ifdef DEST_TRACKER_STATS_EN
  logic [15:0]       stat_stall_cnt;
  logic [15:0]       stat_flush_cnt;
  logic [15:0]       stat_freeze_cnt;
`endif

  modport master (
    output rd_idex, regwrite_idex, memread_idex, alu_result_ex,
    output rs1_ifid, rs2_ifid, use_rs1_ifid, use_rs2_ifid,
    output branch_taken_ex, mem_rdata, mem_ready,
    input  rd_exmem, rd_memwb, regwrite_exmem, regwrite_memwb,
    input  memread_exmem, alu_result_exmem, wb_data_memwb,
    input  pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble,
    input  mem_err
`ifdef DEST_TRACKER_STATS_EN
    , input stat_stall_cnt, stat_flush_cnt, stat_freeze_cnt
`endif
  );

  modport slave (
    input  rd_idex, regwrite_idex, memread_idex, alu_result_ex,
    input  rs1_ifid, rs2_ifid, use_rs1_ifid, use_rs2_ifid,
    input  branch_taken_ex, mem_rdata, mem_ready,
    output rd_exmem, rd_memwb, regwrite_exmem, regwrite_memwb,
    output memread_exmem, alu_result_exmem, wb_data_memwb,
    output pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble,
    output mem_err
`ifdef DEST_TRACKER_STATS_EN
    , output stat_stall_cnt, stat_flush_cnt, stat_freeze_cnt
`endif
  );
endinterface

// File: rtl/dest_tracker.sv
// EX/MEM and MEM/WB destination tracking plus stall/flush/freeze control.
// Optional 16-bit event counters enabled by DEST_TRACKER_STATS_EN.
module dest_tracker #(
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input logic           clk,
  input logic           reset,
  dest_tracker_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOAD_WAIT, ERR_RELEASE} state_t;

  localparam logic [7:0] WAIT_CNT_MAX = 8'(WAIT_MAX);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic [REG_AW-1:0] rd_exmem_q, rd_exmem_d;
  logic              regwrite_exmem_q, regwrite_exmem_d;
  logic              memread_exmem_q, memread_exmem_d;
  logic [DATA_W-1:0] alu_result_exmem_q, alu_result_exmem_d;
  logic [REG_AW-1:0] rd_memwb_q, rd_memwb_d;
  logic              regwrite_memwb_q, regwrite_memwb_d;
  logic [DATA_W-1:0] wb_data_memwb_q, wb_data_memwb_d;

  logic freeze;
  logic load_use;
  logic flush_act;
  logic stall_act;

  assign freeze = memread_exmem_q & ~bus.mem_ready &
                  ((state_q == RUN) | (state_q == LOAD_WAIT));

  assign load_use = bus.memread_idex & bus.regwrite_idex & (bus.rd_idex != '0) &
                    ((bus.use_rs1_ifid & (bus.rd_idex == bus.rs1_ifid)) |
                     (bus.use_rs2_ifid & (bus.rd_idex == bus.rs2_ifid)));

  assign flush_act = bus.branch_taken_ex & ~freeze;
  assign stall_act = load_use & ~freeze & ~bus.branch_taken_ex;

  always_comb begin
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.idex_hold   = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (freeze) begin
      bus.pc_hold   = 1'b1;
      bus.ifid_hold = 1'b1;
      bus.idex_hold = 1'b1;
    end else if (flush_act) begin
      // The ID instruction is discarded, so a pending load-use match is moot.
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (stall_act) begin
      bus.pc_hold     = 1'b1;
      bus.ifid_hold   = 1'b1;
      bus.idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (memread_exmem_q & ~bus.mem_ready) begin
          state_d    = LOAD_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      LOAD_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_CNT_MAX) begin
          state_d   = ERR_RELEASE;
          mem_err_d = 1'b1;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR_RELEASE: state_d = RUN;
      default:     state_d = RUN;
    endcase
  end

  always_comb begin
    rd_exmem_d         = rd_exmem_q;
    regwrite_exmem_d   = regwrite_exmem_q;
    memread_exmem_d    = memread_exmem_q;
    alu_result_exmem_d = alu_result_exmem_q;
    rd_memwb_d         = rd_memwb_q;
    regwrite_memwb_d   = regwrite_memwb_q;
    wb_data_memwb_d    = wb_data_memwb_q;
    if (freeze) begin
      // Bubble into WB so the stalled load's predecessor writes back only once.
      regwrite_memwb_d = 1'b0;
    end else begin
      rd_exmem_d         = bus.rd_idex;
      regwrite_exmem_d   = bus.regwrite_idex;
      memread_exmem_d    = bus.memread_idex;
      alu_result_exmem_d = bus.alu_result_ex;
      rd_memwb_d         = rd_exmem_q;
      regwrite_memwb_d   = regwrite_exmem_q;
      wb_data_memwb_d    = memread_exmem_q ? bus.mem_rdata : alu_result_exmem_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= RUN;
      wait_cnt_q         <= 8'd0;
      mem_err_q          <= 1'b0;
      rd_exmem_q         <= '0;
      regwrite_exmem_q   <= 1'b0;
      memread_exmem_q    <= 1'b0;
      alu_result_exmem_q <= '0;
      rd_memwb_q         <= '0;
      regwrite_memwb_q   <= 1'b0;
      wb_data_memwb_q    <= '0;
    end else begin
      state_q            <= state_d;
      wait_cnt_q         <= wait_cnt_d;
      mem_err_q          <= mem_err_d;
      rd_exmem_q         <= rd_exmem_d;
      regwrite_exmem_q   <= regwrite_exmem_d;
      memread_exmem_q    <= memread_exmem_d;
      alu_result_exmem_q <= alu_result_exmem_d;
      rd_memwb_q         <= rd_memwb_d;
      regwrite_memwb_q   <= regwrite_memwb_d;
      wb_data_memwb_q    <= wb_data_memwb_d;
    end
  end

  assign bus.rd_exmem         = rd_exmem_q;
  assign bus.regwrite_exmem   = regwrite_exmem_q;
  assign bus.memread_exmem    = memread_exmem_q;
  assign bus.alu_result_exmem = alu_result_exmem_q;
  assign bus.rd_memwb         = rd_memwb_q;
  assign bus.regwrite_memwb   = regwrite_memwb_q;
  assign bus.wb_data_memwb    = wb_data_memwb_q;
  assign bus.mem_err          = mem_err_q;

`ifdef DEST_TRACKER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] freeze_cnt_q, freeze_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall_act && stall_cnt_q != 16'hFFFF)  stall_cnt_d  = stall_cnt_q + 16'd1;
    if (flush_act && flush_cnt_q != 16'hFFFF)  flush_cnt_d  = flush_cnt_q + 16'd1;
    if (freeze && freeze_cnt_q != 16'hFFFF)    freeze_cnt_d = freeze_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      freeze_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.stat_stall_cnt  = stall_cnt_q;
  assign bus.stat_flush_cnt  = flush_cnt_q;
  assign bus.stat_freeze_cnt = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_dest_tracker.sv
// Directed bench for dest_tracker: hazard vector table plus freeze, timeout and reset sequences.
module tb_dest_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dest_tracker_if #(.REG_AW(5), .DATA_W(32)) bus ();
  dest_tracker_if #(.REG_AW(5), .DATA_W(32)) bus2 ();

  dest_tracker #(.REG_AW(5), .DATA_W(32), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  dest_tracker #(.REG_AW(5), .DATA_W(32), .WAIT_MAX(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [4:0] exp_ctl; // {pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [31:0] alu);
    bus.rd_idex = rd; bus.regwrite_idex = rw; bus.memread_idex = mr; bus.alu_result_ex = alu;
  endtask

  task automatic drive_ex2(input logic [4:0] rd, input logic rw, input logic mr,
                           input logic [31:0] alu);
    bus2.rd_idex = rd; bus2.regwrite_idex = rw; bus2.memread_idex = mr; bus2.alu_result_ex = alu;
  endtask

  function automatic logic [4:0] ctl1();
    return {bus.pc_hold, bus.ifid_hold, bus.idex_hold, bus.ifid_flush, bus.idex_bubble};
  endfunction

  initial begin
    drive_ex(5'd0, 1'b0, 1'b0, 32'd0);
    bus.rs1_ifid = '0; bus.rs2_ifid = '0; bus.use_rs1_ifid = 0; bus.use_rs2_ifid = 0;
    bus.branch_taken_ex = 0; bus.mem_rdata = '0; bus.mem_ready = 1'b1;
    drive_ex2(5'd0, 1'b0, 1'b0, 32'd0);
    bus2.rs1_ifid = '0; bus2.rs2_ifid = '0; bus2.use_rs1_ifid = 0; bus2.use_rs2_ifid = 0;
    bus2.branch_taken_ex = 0; bus2.mem_rdata = '0; bus2.mem_ready = 1'b1;

    //            rd     rw mr rs1    rs2    u1 u2 br  ctl
    vecs[0] = '{5'd0,  0, 0, 5'd0,  5'd0,  0, 0, 0, 5'b00000};
    vecs[1] = '{5'd5,  1, 1, 5'd5,  5'd1,  1, 0, 0, 5'b11001};
    vecs[2] = '{5'd5,  1, 1, 5'd2,  5'd5,  0, 1, 0, 5'b11001};
    vecs[3] = '{5'd5,  1, 1, 5'd5,  5'd1,  0, 0, 0, 5'b00000};
    vecs[4] = '{5'd0,  1, 1, 5'd0,  5'd0,  1, 1, 0, 5'b00000};
    vecs[5] = '{5'd5,  1, 0, 5'd5,  5'd5,  1, 1, 0, 5'b00000};
    vecs[6] = '{5'd5,  0, 1, 5'd5,  5'd5,  1, 1, 0, 5'b00000};
    vecs[7] = '{5'd5,  1, 1, 5'd5,  5'd0,  1, 0, 1, 5'b00011};
    vecs[8] = '{5'd0,  0, 0, 5'd0,  5'd0,  0, 0, 1, 5'b00011};
    vecs[9] = '{5'd31, 1, 1, 5'd3,  5'd31, 1, 1, 0, 5'b11001};

    // Reset state while reset is held.
    #12;
    chk("reset_ctl", {27'd0, ctl1()}, 32'd0);
    chk("reset_regs", {bus.rd_exmem, bus.rd_memwb, bus.regwrite_exmem, bus.regwrite_memwb,
                       bus.memread_exmem, bus.mem_err}, 32'd0);
    chk("reset_wb", bus.wb_data_memwb, 32'd0);
    chk("reset_alu", bus.alu_result_exmem, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Combinational hazard table; memory always ready so nothing freezes.
    for (int i = 0; i < 10; i++) begin
      drive_ex(vecs[i].rd, vecs[i].rw, vecs[i].mr, 32'h100 + 32'(i));
      bus.rs1_ifid = vecs[i].rs1; bus.rs2_ifid = vecs[i].rs2;
      bus.use_rs1_ifid = vecs[i].u1; bus.use_rs2_ifid = vecs[i].u2;
      bus.branch_taken_ex = vecs[i].br;
      #1;
      chk($sformatf("vec%0d_ctl", i), {27'd0, ctl1()}, {27'd0, vecs[i].exp_ctl});
      tick();
      chk($sformatf("vec%0d_exmem", i), {25'd0, bus.rd_exmem, bus.regwrite_exmem, bus.memread_exmem},
          {25'd0, vecs[i].rd, vecs[i].rw, vecs[i].mr});
    end

    // Load-use stall lasts one cycle; the load then sits in MEM.
    bus.branch_taken_ex = 0; bus.use_rs2_ifid = 0;
    drive_ex(5'd5, 1, 1, 32'd0); bus.rs1_ifid = 5'd5; bus.use_rs1_ifid = 1;
    #1 chk("lu_stall", {27'd0, ctl1()}, 32'b11001);
    tick();
    drive_ex(5'd0, 0, 0, 32'd0);
    #1 chk("lu_next_ctl", {27'd0, ctl1()}, 32'd0);
    chk("lu_next_exmem", {26'd0, bus.rd_exmem, bus.memread_exmem}, {26'd0, 5'd5, 1'b1});
    bus.use_rs1_ifid = 0;

    // Load waits 3 cycles; a branch in EX is held back until release.
    tick();
    drive_ex(5'd3, 1, 0, 32'h11);
    tick();
    drive_ex(5'd7, 1, 1, 32'h99);
    tick();
    chk("alu_wb", {bus.rd_memwb, bus.regwrite_memwb, 26'd0}, {5'd3, 1'b1, 26'd0});
    chk("alu_wb_data", bus.wb_data_memwb, 32'h11);
    drive_ex(5'd0, 0, 0, 32'd0);
    bus.branch_taken_ex = 1; bus.mem_ready = 0;
    #1 chk("frz0_ctl", {27'd0, ctl1()}, 32'b11100);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("frz%0d_rw_memwb", k), {31'd0, bus.regwrite_memwb}, 32'd0);
      #1 chk($sformatf("frz%0d_ctl", k), {27'd0, ctl1()}, 32'b11100);
    end
    tick();
    chk("frz3_rw_memwb", {31'd0, bus.regwrite_memwb}, 32'd0);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    #1 chk("release_flush", {27'd0, ctl1()}, 32'b00011);
    tick();
    bus.branch_taken_ex = 0;
    chk("load_wb", {bus.rd_memwb, bus.regwrite_memwb, 26'd0}, {5'd7, 1'b1, 26'd0});
    chk("load_wb_data", bus.wb_data_memwb, 32'hDEADBEEF);
    chk("no_err", {31'd0, bus.mem_err}, 32'd0);
    tick();
    chk("load_wb_once", {31'd0, bus.regwrite_memwb}, 32'd0);

    // Timeout on the WAIT_MAX=2 instance.
    drive_ex2(5'd9, 1, 1, 32'h55); bus2.mem_ready = 0;
    tick();
    drive_ex2(5'd0, 0, 0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("to_c%0d_frz", c), {30'd0, bus2.pc_hold, bus2.mem_err}, 32'b10);
      tick();
    end
    bus2.mem_rdata = 32'hCAFE0001;
    chk("to_release", {30'd0, bus2.pc_hold, bus2.mem_err}, 32'b01);
    tick();
    chk("to_wb", {bus2.rd_memwb, bus2.regwrite_memwb, bus2.mem_err, 25'd0},
        {5'd9, 1'b1, 1'b1, 25'd0});
    chk("to_wb_data", bus2.wb_data_memwb, 32'hCAFE0001);
    drive_ex2(5'd10, 1, 1, 32'd0); bus2.mem_ready = 1;
    tick();
    drive_ex2(5'd0, 0, 0, 32'd0);
    #1 chk("post_to_load", {30'd0, bus2.pc_hold, bus2.mem_err}, 32'b01);
    tick();
    chk("post_to_wb", {26'd0, bus2.rd_memwb, bus2.mem_err}, {26'd0, 5'd10, 1'b1});

    // Asynchronous reset in the middle of LOAD_WAIT.
    drive_ex(5'd4, 1, 1, 32'h77); bus.mem_ready = 0;
    tick();
    drive_ex(5'd0, 0, 0, 32'd0);
    tick();
    chk("lw_frozen", {31'd0, bus.pc_hold}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_ctl", {27'd0, ctl1()}, 32'd0);
    chk("arst_regs", {bus.rd_exmem, bus.rd_memwb, bus.regwrite_exmem, bus.regwrite_memwb,
                      bus.memread_exmem, bus.mem_err}, 32'd0);
    chk("arst_data", bus.wb_data_memwb | bus.alu_result_exmem, 32'd0);
    chk("arst_err2", {31'd0, bus2.mem_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    #1 chk("after_arst_run", {31'd0, bus.pc_hold}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
